// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: bus width,
// FSM state encoding and pipeline stall vectors.
package mem_arbiter_pkg;

    localparam int RegBus = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    // Stall vector bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
    localparam logic [5:0] StallMem = 6'b011111;
    localparam logic [5:0] StallIf  = 6'b000011;
    localparam logic [5:0] NoStall  = 6'b000000;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (IF) and load/store (MEM) ports onto one registered
// memory bus; MEM has fixed priority and every transaction is bounded by TIMEOUT.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [RegBus-1:0] if_addr_i,
    output logic [RegBus-1:0] if_rdata_o,
    output logic              if_ack_o,

    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [RegBus-1:0] mem_addr_i,
    input  logic [RegBus-1:0] mem_wdata_i,
    output logic [RegBus-1:0] mem_rdata_o,
    output logic              mem_ack_o,

    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [RegBus-1:0] bus_addr_o,
    output logic [RegBus-1:0] bus_wdata_o,
    input  logic [RegBus-1:0] bus_rdata_i,
    input  logic              bus_ready_i,

    output logic [5:0]        stall_o,
    output logic              err_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             busy;
    logic             timeout;

    assign busy    = (state == IF_BUSY) || (state == MEM_BUSY);
    assign timeout = busy && !bus_ready_i && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            bus_ce_o    <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            err_o       <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    // A requester whose ack is showing is still holding req; it must not be re-granted.
                    if (mem_req_i && !mem_ack_o) begin
                        state       <= MEM_BUSY;
                        bus_ce_o    <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                    end else if (if_req_i && !if_ack_o) begin
                        state       <= IF_BUSY;
                        bus_ce_o    <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= 4'b1111;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    if (bus_ready_i || timeout) begin
                        state    <= IDLE;
                        bus_ce_o <= 1'b0;
                        err_o    <= !bus_ready_i;
                        if (state == IF_BUSY) begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= bus_ready_i ? bus_rdata_i : '0;
                        end else begin
                            mem_ack_o <= 1'b1;
                            // Stores never disturb the last load result.
                            if (!bus_we_o) begin
                                mem_rdata_o <= bus_ready_i ? bus_rdata_i : '0;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus_ce_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_o = NoStall;
        if (rst) begin
            stall_o = NoStall;
        end else if (mem_req_i && !mem_ack_o) begin
            stall_o = StallMem;
        end else if (if_req_i && !if_ack_o) begin
            stall_o = StallIf;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random transactions
// predicted from per-transaction latency/timeout arithmetic.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ready_i;
    logic [5:0]  stall_o;
    logic        err_o;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_sel_i   (mem_sel_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ack_o   (mem_ack_o),
        .bus_ce_o    (bus_ce_o),
        .bus_we_o    (bus_we_o),
        .bus_sel_o   (bus_sel_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ready_i (bus_ready_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ce"},      32'(bus_ce_o),  32'd0);
        chk({tag, "_ifack"},   32'(if_ack_o),  32'd0);
        chk({tag, "_memack"},  32'(mem_ack_o), 32'd0);
        chk({tag, "_err"},     32'(err_o),     32'd0);
        chk({tag, "_ifrd"},    if_rdata_o,     exp_if_rdata);
        chk({tag, "_memrd"},   mem_rdata_o,    exp_mem_rdata);
    endtask

    // One complete transaction. The slave asserts ready in busy cycle delay+1;
    // the arbiter gives up after TO busy cycles, so the outcome is plain arithmetic.
    task automatic transact(input bit is_mem, input bit we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int delay, input bit drop);
        int         n;
        bit         err;
        logic [5:0] enc;
        logic [3:0] esel;
        bit         ewe;
        n    = (delay < TO) ? delay + 1 : TO;
        err  = (delay >= TO);
        enc  = is_mem ? StallMem : StallIf;
        ewe  = is_mem && we;
        esel = is_mem ? sel : 4'hF;
        if (is_mem) begin
            mem_req_i = 1'b1; mem_we_i = we; mem_sel_i = sel;
            mem_addr_i = addr; mem_wdata_i = wdata;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        bus_ready_i = 1'b0;
        #1;
        chk("stall_req", 32'(stall_o), 32'(enc));
        step();
        if (drop) begin
            mem_req_i = 1'b0;
            if_req_i  = 1'b0;
        end
        for (int k = 1; k <= n; k++) begin
            bus_ready_i = (k == delay + 1);
            bus_rdata_i = bus_ready_i ? rdata : $urandom;
            mem_addr_i  = $urandom;
            mem_wdata_i = $urandom;
            if_addr_i   = $urandom;
            #1;
            chk("busy_ce",    32'(bus_ce_o),  32'd1);
            chk("busy_we",    32'(bus_we_o),  32'(ewe));
            chk("busy_sel",   32'(bus_sel_o), 32'(esel));
            chk("busy_addr",  bus_addr_o,     addr);
            if (is_mem) chk("busy_wdata", bus_wdata_o, wdata);
            chk("busy_ack",   32'({if_ack_o, mem_ack_o}), 32'd0);
            chk("busy_err",   32'(err_o),     32'd0);
            chk("busy_stall", 32'(stall_o),   drop ? 32'd0 : 32'(enc));
            step();
        end
        bus_ready_i = 1'b0;
        if (!is_mem)  exp_if_rdata  = err ? 32'd0 : rdata;
        else if (!we) exp_mem_rdata = err ? 32'd0 : rdata;
        chk("done_ifack",  32'(if_ack_o),  32'(!is_mem));
        chk("done_memack", 32'(mem_ack_o), 32'(is_mem));
        chk("done_err",    32'(err_o),     32'(err));
        chk("done_ifrd",   if_rdata_o,     exp_if_rdata);
        chk("done_memrd",  mem_rdata_o,    exp_mem_rdata);
        chk("done_ce",     32'(bus_ce_o),  32'd0);
        chk("done_stall",  32'(stall_o),   32'd0);
        // Requester still holds req across this edge, as a real upstream would.
        step();
        chk_quiet("after");
        mem_req_i = 1'b0;
        if_req_i  = 1'b0;
    endtask

    bit          r_mem, r_we, r_drop;
    logic [3:0]  r_sel;
    logic [31:0] r_addr, r_wdata, r_rdata;
    int          r_delay, r_gap;

    initial begin
        rst = 1'b1;
        if_req_i = 1'b1; if_addr_i = '0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = '0;
        mem_addr_i = '0; mem_wdata_i = '0;
        bus_rdata_i = '0; bus_ready_i = 1'b0;
        exp_if_rdata = '0; exp_mem_rdata = '0;

        // Reset state, with both requests asserted to show stall is suppressed.
        step(); step();
        chk_quiet("rst");
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_bus",   32'({bus_we_o, bus_sel_o}), 32'd0);
        chk("rst_addr",  bus_addr_o,  32'd0);
        chk("rst_wdata", bus_wdata_o, 32'd0);
        if_req_i = 1'b0; mem_req_i = 1'b0;
        rst = 1'b0;
        step();
        chk_quiet("idle");

        // Fetch with minimum latency.
        transact(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h3401FFFF, 0, 1'b0);

        // Simultaneous requests: MEM first, IF granted in the ack cycle.
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h100;
        if_req_i = 1'b1; if_addr_i = 32'h44;
        #1;
        chk("both_stall", 32'(stall_o), 32'(StallMem));
        step();
        chk("both_ce",   32'(bus_ce_o), 32'd1);
        chk("both_addr", bus_addr_o,    32'h100);
        chk("both_we",   32'(bus_we_o), 32'd0);
        bus_ready_i = 1'b1; bus_rdata_i = 32'hCAFE0001;
        step();
        bus_ready_i = 1'b0;
        exp_mem_rdata = 32'hCAFE0001;
        chk("both_memack", 32'(mem_ack_o), 32'd1);
        chk("both_ifack0", 32'(if_ack_o),  32'd0);
        chk("both_memrd",  mem_rdata_o,    exp_mem_rdata);
        chk("both_ce0",    32'(bus_ce_o),  32'd0);
        mem_req_i = 1'b0;
        #1;
        chk("both_stall_if", 32'(stall_o), 32'(StallIf));
        step();
        chk("if2_ce",     32'(bus_ce_o),  32'd1);
        chk("if2_addr",   bus_addr_o,     32'h44);
        chk("if2_sel",    32'(bus_sel_o), 32'hF);
        chk("if2_memack", 32'(mem_ack_o), 32'd0);
        bus_ready_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
        step();
        bus_ready_i = 1'b0;
        exp_if_rdata = 32'h0BADF00D;
        chk("if2_ack", 32'(if_ack_o), 32'd1);
        chk("if2_rd",  if_rdata_o,    exp_if_rdata);
        step();
        chk_quiet("if2_after");
        if_req_i = 1'b0;

        // Store with ready three cycles late; load result must survive it.
        transact(1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEADBEEF, 32'h55AA55AA, 3, 1'b0);
        // Timeout boundaries: ready on the last allowed cycle, then never.
        transact(1'b0, 1'b0, 4'h0, 32'h300, 32'h0, 32'h12345678, TO - 1, 1'b0);
        transact(1'b0, 1'b0, 4'h0, 32'h304, 32'h0, 32'h9ABCDEF0, 100, 1'b0);
        transact(1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 32'h11112222, 0, 1'b0);
        transact(1'b1, 1'b0, 4'hF, 32'h404, 32'h0, 32'h33334444, TO, 1'b0);
        // Requester abandons the transaction; the ack still pulses.
        transact(1'b1, 1'b0, 4'hF, 32'h408, 32'h0, 32'h77778888, 1, 1'b1);

        // Reset in the second busy cycle aborts the fetch.
        exp_if_rdata = if_rdata_o === 32'h0 ? 32'h0 : exp_if_rdata;
        if_req_i = 1'b1; if_addr_i = 32'h80; bus_ready_i = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        step();
        exp_if_rdata = '0; exp_mem_rdata = '0;
        chk_quiet("mid_rst");
        chk("mid_rst_addr", bus_addr_o, 32'd0);
        chk("mid_rst_sel",  32'({bus_we_o, bus_sel_o}), 32'd0);
        rst = 1'b0; if_req_i = 1'b0;
        step();
        chk_quiet("post_rst1");
        step();
        chk_quiet("post_rst2");
        transact(1'b0, 1'b0, 4'h0, 32'h84, 32'h0, 32'h600DF00D, 1, 1'b0);

        // Random transactions.
        for (int i = 0; i < 40; i++) begin
            r_mem   = 1'($urandom_range(0, 1));
            r_we    = 1'($urandom_range(0, 1));
            r_drop  = ($urandom_range(0, 7) == 0);
            r_sel   = 4'($urandom);
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_delay = int'($urandom_range(0, 5));
            r_gap   = int'($urandom_range(0, 2));
            transact(r_mem, r_we, r_sel, r_addr, r_wdata, r_rdata, r_delay, r_drop);
            for (int g = 0; g < r_gap; g++) begin
                step();
                chk_quiet("gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
